// File: rtl/fetch_inst_buffer_if.sv
// Handshake bundle between the fetch unit, the instruction buffer and the backend.
// The slave modport is the buffer's view; the master modport drives fetch lanes and backend controls.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

interface fetch_inst_buffer_if #(
  parameter int FETCH_WIDTH = `FETCH_WIDTH,
  parameter int INST_W      = 32,
  parameter int CNT_W       = 5
);
  logic                                i_squash_vld;
  logic [FETCH_WIDTH-1:0]              i_enq_vld;
  logic [FETCH_WIDTH-1:0][INST_W-1:0]  i_enq_inst;
  logic                                o_enq_rdy;
  logic                                i_stall;
  logic [FETCH_WIDTH-1:0]              o_inst_vld;
  logic [FETCH_WIDTH-1:0][INST_W-1:0]  o_inst;
  logic [CNT_W-1:0]                    o_count;

  modport slave (
    input  i_squash_vld, i_enq_vld, i_enq_inst, i_stall,
    output o_enq_rdy, o_inst_vld, o_inst, o_count
  );

  modport master (
    output i_squash_vld, i_enq_vld, i_enq_inst, i_stall,
    input  o_enq_rdy, o_inst_vld, o_inst, o_count
  );
endinterface

// File: rtl/fetch_inst_buffer.sv
// Circular instruction buffer decoupling fetch from decode: compacts sparse fetch lanes on
// enqueue and presents up to FETCH_WIDTH oldest entries per cycle, all-or-nothing dequeue.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

module fetch_inst_buffer #(
  parameter int DEPTH       = 16,
  parameter int FETCH_WIDTH = `FETCH_WIDTH,
  parameter int INST_W      = 32
) (
  input logic                clk,
  input logic                rst,
  fetch_inst_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(FETCH_WIDTH) + 1;

  logic [INST_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              enq_rdy;
  logic              enq_fire;
  logic              deq_fire;
  logic [LANE_W-1:0] n_enq;
  logic [LANE_W-1:0] n_avail;
  logic [LANE_W-1:0] n_deq;
  logic [FETCH_WIDTH-1:0][LANE_W-1:0] lane_off;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_enq    = '0;
    lane_off = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      lane_off[j] = n_enq;
      n_enq       = n_enq + LANE_W'(bus.i_enq_vld[j]);
    end
  end

  // Ready looks only at registered occupancy, so a same-cycle dequeue earns no credit.
  assign enq_rdy  = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
  assign n_avail  = (count >= CNT_W'(FETCH_WIDTH)) ? LANE_W'(FETCH_WIDTH) : LANE_W'(count);
  assign enq_fire = enq_rdy && (|bus.i_enq_vld) && !bus.i_squash_vld;
  assign deq_fire = !bus.i_stall && !bus.i_squash_vld;
  assign n_deq    = deq_fire ? n_avail : '0;

  always_ff @(posedge clk) begin
    if (rst || bus.i_squash_vld) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + PTR_W'(n_enq);
      end
      head  <= head + PTR_W'(n_deq);
      count <= count + (enq_fire ? CNT_W'(n_enq) : CNT_W'(0)) - CNT_W'(n_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire && !rst) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (bus.i_enq_vld[j]) begin
          storage[tail + PTR_W'(lane_off[j])] <= bus.i_enq_inst[j];
        end
      end
    end
  end

  always_comb begin
    bus.o_inst_vld = '0;
    bus.o_inst     = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      bus.o_inst_vld[k] = !bus.i_squash_vld && (LANE_W'(k) < n_avail);
      bus.o_inst[k]     = storage[head + PTR_W'(k)];
    end
  end

  assign bus.o_enq_rdy = enq_rdy;
  assign bus.o_count   = count;

  // Occupancy must agree with the pointer distance; a full buffer has equal pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CNT_W'(DEPTH) && count[PTR_W-1:0] == PTR_W'(tail - head));
    end
  end
endmodule
